// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the sequencer state encoding, the pipeline NOP encoding and the
// default vector-ALU latency.
package hazard_pkg;

    localparam int unsigned VALU_LAT_DEFAULT = 4;
    localparam int unsigned VCNT_W           = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        VALU_WAIT = 2'd1,
        MEM_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_stall_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
// Ports: clk_i, rst_i, en_i (count this edge), cnt_o (current count).
module stall_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Hold at all-ones once reached.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Inputs: ID source registers/uses, EX rd/load/vector flags, branch taken,
//         data-memory request/ready handshake.
// Outputs: per-stage write enables and flush/bubble controls (combinational
//          from state, VALU countdown and inputs), VALU start pulse,
//          sequencer state and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned VALU_LAT = VALU_LAT_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             ex_valu_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_we_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_we_o,
    output logic             ex_mem_bubble_o,
    output logic             mem_wb_bubble_o,
    output logic             valu_start_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam logic [VCNT_W-1:0] VCNT_LOAD = VCNT_W'(VALU_LAT - 1);
    localparam logic              VALU_MULTI = (VALU_LAT > 1);

    state_e              state_q, state_d;
    logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
    logic                mem_stall;
    logic                load_use;

    assign mem_stall = mem_req_i & ~mem_ready_i;
    assign load_use  = ex_memread_i & (ex_rd_i != 5'd0) &
                       ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                        (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

    // Next-state and stage controls.
    always_comb begin
        state_d         = state_q;
        vcnt_d          = vcnt_q;
        pc_we_o         = 1'b1;
        if_id_we_o      = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_we_o      = 1'b1;
        id_ex_flush_o   = 1'b0;
        ex_mem_we_o     = 1'b1;
        ex_mem_bubble_o = 1'b0;
        mem_wb_bubble_o = 1'b0;
        valu_start_o    = 1'b0;

        if (rst_i) begin
            pc_we_o         = 1'b0;
            if_id_we_o      = 1'b0;
            id_ex_we_o      = 1'b0;
            ex_mem_we_o     = 1'b0;
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
            ex_mem_bubble_o = 1'b1;
            mem_wb_bubble_o = 1'b1;
            state_d         = RUN;
            vcnt_d          = '0;
        end else begin
            unique case (state_q)
                // MEM_WAIT without a pending stall behaves exactly like RUN.
                RUN, MEM_WAIT: begin
                    if (mem_stall) begin
                        pc_we_o         = 1'b0;
                        if_id_we_o      = 1'b0;
                        id_ex_we_o      = 1'b0;
                        ex_mem_we_o     = 1'b0;
                        mem_wb_bubble_o = 1'b1;
                        state_d         = MEM_WAIT;
                    end else if (ex_valu_i && VALU_MULTI) begin
                        valu_start_o    = 1'b1;
                        pc_we_o         = 1'b0;
                        if_id_we_o      = 1'b0;
                        id_ex_we_o      = 1'b0;
                        ex_mem_bubble_o = 1'b1;
                        vcnt_d          = VCNT_LOAD;
                        state_d         = VALU_WAIT;
                    end else begin
                        state_d      = RUN;
                        // Single-cycle VALU: start pulse only, no stall.
                        valu_start_o = ex_valu_i;
                        if (branch_taken_i) begin
                            if_id_flush_o = 1'b1;
                            id_ex_flush_o = 1'b1;
                        end else if (load_use) begin
                            pc_we_o       = 1'b0;
                            if_id_we_o    = 1'b0;
                            id_ex_flush_o = 1'b1;
                        end
                    end
                end

                // Vector op occupies EX; branch/load-use do not apply here.
                VALU_WAIT: begin
                    if (vcnt_q > VCNT_W'(1)) begin
                        vcnt_d     = vcnt_q - VCNT_W'(1);
                        pc_we_o    = 1'b0;
                        if_id_we_o = 1'b0;
                        id_ex_we_o = 1'b0;
                        if (mem_stall) begin
                            ex_mem_we_o     = 1'b0;
                            mem_wb_bubble_o = 1'b1;
                        end else begin
                            ex_mem_bubble_o = 1'b1;
                        end
                    end else if (mem_stall) begin
                        // Result ready but MEM is blocked: hold at 1.
                        pc_we_o         = 1'b0;
                        if_id_we_o      = 1'b0;
                        id_ex_we_o      = 1'b0;
                        ex_mem_we_o     = 1'b0;
                        mem_wb_bubble_o = 1'b1;
                    end else begin
                        vcnt_d  = '0;
                        state_d = RUN;
                    end
                end

                default: begin
                    state_d = RUN;
                    vcnt_d  = '0;
                end
            endcase
        end
    end

    // State and VALU countdown registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            vcnt_q  <= vcnt_d;
        end
    end

    assign state_o = state_q;

    stall_counter #(
        .W(CNT_W)
    ) u_stall_counter (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (~pc_we_o),
        .cnt_o(stall_cycles_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// controls/state/count; a monitor pops and compares on the falling edge.
module tb_pipe_hazard_ctrl;

    // Control vector bit order:
    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    //  ex_mem_we, ex_mem_bubble, mem_wb_bubble, valu_start}
    localparam logic [8:0] C_NORM   = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] C_RST    = 9'b0_0_1_0_1_0_1_1_0;
    localparam logic [8:0] C_FRZ    = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] C_LU     = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] C_BR     = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] C_VSTART = 9'b0_0_0_0_0_1_1_0_1;
    localparam logic [8:0] C_VSTALL = 9'b0_0_0_0_0_1_1_0_0;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_VW   = 2'd1;
    localparam logic [1:0] S_MW   = 2'd2;

    typedef struct {
        string       name;
        logic [8:0]  ctl;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_memread, ex_valu;
    logic        branch_taken, mem_req, mem_ready;
    logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic        ex_mem_we, ex_mem_bubble, mem_wb_bubble, valu_start;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    exp_t        sb_q[$];
    int          n_tests;
    int          n_fail;
    logic [31:0] cnt_model;

    pipe_hazard_ctrl #(
        .VALU_LAT(4),
        .CNT_W   (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_uses_rs1_i  (id_uses_rs1),
        .id_uses_rs2_i  (id_uses_rs2),
        .ex_rd_i        (ex_rd),
        .ex_memread_i   (ex_memread),
        .ex_valu_i      (ex_valu),
        .branch_taken_i (branch_taken),
        .mem_req_i      (mem_req),
        .mem_ready_i    (mem_ready),
        .pc_we_o        (pc_we),
        .if_id_we_o     (if_id_we),
        .if_id_flush_o  (if_id_flush),
        .id_ex_we_o     (id_ex_we),
        .id_ex_flush_o  (id_ex_flush),
        .ex_mem_we_o    (ex_mem_we),
        .ex_mem_bubble_o(ex_mem_bubble),
        .mem_wb_bubble_o(mem_wb_bubble),
        .valu_start_o   (valu_start),
        .state_o        (state),
        .stall_cycles_o (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue the
    // expected response. An rst of 1 here lands between edges (async).
    task automatic step(input string nm, input logic r,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic mrd,
                        input logic v, input logic br,
                        input logic mq, input logic mr,
                        input logic [8:0] ctl, input logic [1:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        id_rs1       = rs1;
        id_uses_rs1  = u1;
        id_rs2       = rs2;
        id_uses_rs2  = u2;
        ex_rd        = rd;
        ex_memread   = mrd;
        ex_valu      = v;
        branch_taken = br;
        mem_req      = mq;
        mem_ready    = mr;
        e.name = nm;
        e.ctl  = ctl;
        e.st   = st;
        e.cnt  = r ? 32'd0 : cnt_model;
        sb_q.push_back(e);
        if (r) cnt_model = 32'd0;
        else if (!ctl[8]) cnt_model = cnt_model + 32'd1;
    endtask

    // Monitor: compare DUT outputs against the scoreboard head.
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                       ex_mem_we, ex_mem_bubble, mem_wb_bubble, valu_start};
                n_tests++;
                if (act !== e.ctl) begin
                    n_fail++;
                    $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
                end
                n_tests++;
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL %s state: got %0d expected %0d", e.name, state, e.st);
                end
                n_tests++;
                if (stall_cycles !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s stall_cycles: got %0d expected %0d",
                             e.name, stall_cycles, e.cnt);
                end
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; cnt_model = 32'd0;
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_memread = 0; ex_valu = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;

        //     name        rst rs1 u1 rs2 u2 rd mrd v br mq mr  ctl       state
        step("reset0",     1,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, C_RST,    S_RUN);
        step("reset1",     1,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, C_RST,    S_RUN);
        step("idle0",      0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, C_NORM,   S_RUN);
        // Load-use on rs1, then normal flow with count 1.
        step("lu_rs1",     0,  5, 1,  0, 0,  5, 1, 0, 0, 0, 0, C_LU,     S_RUN);
        step("lu_after",   0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, C_NORM,   S_RUN);
        step("lu_x0",      0,  0, 1,  0, 0,  0, 1, 0, 0, 0, 0, C_NORM,   S_RUN);
        step("lu_rs2",     0,  3, 1,  7, 1,  7, 1, 0, 0, 0, 0, C_LU,     S_RUN);
        step("lu_nouse",   0,  7, 0,  7, 0,  7, 1, 0, 0, 0, 0, C_NORM,   S_RUN);
        step("lu_noload",  0,  5, 1,  0, 0,  5, 0, 0, 0, 0, 0, C_NORM,   S_RUN);
        step("br_over_lu", 0,  5, 1,  0, 0,  5, 1, 0, 1, 0, 0, C_BR,     S_RUN);
        // Vector op, LAT=4: start + 2 stalls + release; branch ignored in wait.
        step("v_start",    0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, C_VSTART, S_RUN);
        step("v_wait3",    0,  0, 0,  0, 0,  0, 0, 1, 1, 0, 0, C_VSTALL, S_VW);
        step("v_wait2",    0,  5, 1,  0, 0,  5, 1, 1, 0, 0, 0, C_VSTALL, S_VW);
        step("v_release",  0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, C_NORM,   S_VW);
        step("v_after",    0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, C_NORM,   S_RUN);
        // Five-cycle memory stall; ready cycle behaves like RUN (load-use).
        step("m_stall1",   0,  0, 0,  0, 0,  0, 0, 0, 0, 1, 0, C_FRZ,    S_RUN);
        step("m_stall2",   0,  0, 0,  0, 0,  0, 0, 1, 1, 1, 0, C_FRZ,    S_MW);
        step("m_stall3",   0,  0, 0,  0, 0,  0, 0, 0, 0, 1, 0, C_FRZ,    S_MW);
        step("m_stall4",   0,  0, 0,  0, 0,  0, 0, 0, 0, 1, 0, C_FRZ,    S_MW);
        step("m_stall5",   0,  0, 0,  0, 0,  0, 0, 0, 0, 1, 0, C_FRZ,    S_MW);
        step("m_ready_lu", 0,  9, 1,  0, 0,  9, 1, 0, 0, 1, 1, C_LU,     S_MW);
        step("m_after",    0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, C_NORM,   S_RUN);
        // VALU countdown reaches 1 under a memory stall and holds there.
        step("vm_start",   0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, C_VSTART, S_RUN);
        step("vm_wait3",   0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, C_VSTALL, S_VW);
        step("vm_frz2",    0,  0, 0,  0, 0,  0, 0, 1, 0, 1, 0, C_FRZ,    S_VW);
        step("vm_frz1a",   0,  0, 0,  0, 0,  0, 0, 1, 0, 1, 0, C_FRZ,    S_VW);
        step("vm_frz1b",   0,  0, 0,  0, 0,  0, 0, 1, 0, 1, 0, C_FRZ,    S_VW);
        step("vm_release", 0,  0, 0,  0, 0,  0, 0, 1, 0, 1, 1, C_NORM,   S_VW);
        step("vm_after",   0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, C_NORM,   S_RUN);
        // Async reset in VALU_WAIT: immediate RUN, zero count, no start pulse.
        step("vr_start",   0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, C_VSTART, S_RUN);
        step("vr_wait",    0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, C_VSTALL, S_VW);
        step("vr_reset",   1,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, C_RST,    S_RUN);
        step("vr_idle",    0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, C_NORM,   S_RUN);
        step("vr_lu",      0,  4, 0,  4, 1,  4, 1, 0, 0, 0, 0, C_LU,     S_RUN);
        step("vr_after",   0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, C_NORM,   S_RUN);

        repeat (4) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
